// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and period of an asynchronous PWM input in clk cycles.
// Each complete period yields one d_out/t_out pair with a valid strobe; a sticky flag marks a dead input.
module pwm_capture #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 2_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] t_out,
  output logic             valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO  = '0;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state_reg;
  logic             sync1_reg;
  logic             s_reg;
  logic             s_prev_reg;
  logic [WIDTH-1:0] cnt_hi_reg;
  logic [WIDTH-1:0] cnt_per_reg;

  logic rise;
  logic fall;
  logic expired;

  assign rise    = s_reg & ~s_prev_reg;
  assign fall    = ~s_reg & s_prev_reg;
  // A rise on the threshold cycle still closes the period normally.
  assign expired = (cnt_per_reg == LIMIT) && !rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      sync1_reg   <= 1'b0;
      s_reg       <= 1'b0;
      s_prev_reg  <= 1'b0;
      cnt_hi_reg  <= ZERO;
      cnt_per_reg <= ZERO;
      d_out       <= ZERO;
      t_out       <= ZERO;
      valid       <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      sync1_reg  <= pwm_in;
      s_reg      <= sync1_reg;
      s_prev_reg <= s_reg;
      valid      <= 1'b0;

      if (!enable) begin
        state_reg   <= IDLE;
        cnt_hi_reg  <= ZERO;
        cnt_per_reg <= ZERO;
      end else begin
        case (state_reg)
          IDLE: begin
            if (rise) begin
              state_reg   <= HIGH;
              cnt_hi_reg  <= ONE;
              cnt_per_reg <= ONE;
              timeout     <= 1'b0;
            end
          end
          HIGH: begin
            if (expired) begin
              state_reg   <= IDLE;
              cnt_hi_reg  <= ZERO;
              cnt_per_reg <= ZERO;
              timeout     <= 1'b1;
            end else begin
              cnt_per_reg <= cnt_per_reg + ONE;
              if (fall) begin
                state_reg <= LOW;
              end else begin
                cnt_hi_reg <= cnt_hi_reg + ONE;
              end
            end
          end
          LOW: begin
            if (rise) begin
              d_out       <= cnt_hi_reg;
              t_out       <= cnt_per_reg;
              valid       <= 1'b1;
              state_reg   <= HIGH;
              cnt_hi_reg  <= ONE;
              cnt_per_reg <= ONE;
            end else if (expired) begin
              state_reg   <= IDLE;
              cnt_hi_reg  <= ZERO;
              cnt_per_reg <= ZERO;
              timeout     <= 1'b1;
            end else begin
              cnt_per_reg <= cnt_per_reg + ONE;
            end
          end
          default: begin
            state_reg   <= IDLE;
            cnt_hi_reg  <= ZERO;
            cnt_per_reg <= ZERO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: two instances (short and long watchdog) share one stimulus stream,
// checked every cycle against an edge-timestamp model plus literal expectations per scenario.
module tb_pwm_capture;

  localparam int W    = 16;
  localparam int TO_A = 50;
  localparam int TO_B = 1000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] d_a, t_a, d_b, t_b;
  logic         valid_a, valid_b, timeout_a, timeout_b;

  pwm_capture #(.WIDTH(W), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
    .d_out(d_a), .t_out(t_a), .valid(valid_a), .timeout(timeout_a)
  );

  pwm_capture #(.WIDTH(W), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
    .d_out(d_b), .t_out(t_b), .valid(valid_b), .timeout(timeout_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input int d, input int t);
    return {d[15:0], t[15:0]};
  endfunction

  // Model: timestamps of the synchronised waveform's edges; measurements are differences.
  bit samp [0:4095];
  int edge_n = 3;
  bit started = 0;
  int to_lim [2] = '{TO_A, TO_B};
  int m_d [2], m_t [2], last_rise [2], fall_edge [2];
  bit m_valid [2], m_tmo [2], m_active [2], m_fell [2];

  always @(posedge clk) begin
    bit s_cur, s_old, r, f;
    edge_n++;
    s_cur = samp[(edge_n - 2) % 4096];
    s_old = samp[(edge_n - 3) % 4096];
    samp[edge_n % 4096] = pwm_in;
    if (reset) begin
      samp[edge_n % 4096]       = 1'b0;
      samp[(edge_n - 1) % 4096] = 1'b0;
      samp[(edge_n - 2) % 4096] = 1'b0;
    end
    r = s_cur & ~s_old;
    f = ~s_cur & s_old;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      if (reset) begin
        m_d[i] = 0; m_t[i] = 0; m_tmo[i] = 0; m_active[i] = 0; m_fell[i] = 0;
      end else if (!enable) begin
        m_active[i] = 0;
      end else if (r) begin
        if (m_active[i] && m_fell[i]) begin
          m_d[i] = fall_edge[i] - last_rise[i];
          m_t[i] = edge_n - last_rise[i];
          m_valid[i] = 1'b1;
        end
        if (!m_active[i]) m_tmo[i] = 1'b0;
        m_active[i] = 1'b1;
        m_fell[i] = 1'b0;
        last_rise[i] = edge_n;
      end else if (m_active[i]) begin
        if (f && !m_fell[i]) begin
          m_fell[i] = 1'b1;
          fall_edge[i] = edge_n;
        end
        if (edge_n - last_rise[i] == to_lim[i] - 1) begin
          m_active[i] = 1'b0;
          m_tmo[i] = 1'b1;
        end
      end
    end
    started = 1'b1;
  end

  logic [31:0] log_a [$];
  logic [31:0] log_b [$];
  logic [31:0] want  [$];
  int since_valid = 0;
  int to_lat = -1;
  int to_d = -1;
  int to_t = -1;
  bit tmo_prev = 0;

  // Per-cycle comparison against the model, plus event logging.
  always @(negedge clk) begin
    if (started) begin
      check("valid_a", valid_a, m_valid[0]);
      check("d_a", d_a, m_d[0]);
      check("t_a", t_a, m_t[0]);
      check("timeout_a", timeout_a, m_tmo[0]);
      check("valid_b", valid_b, m_valid[1]);
      check("d_b", d_b, m_d[1]);
      check("t_b", t_b, m_t[1]);
      check("timeout_b", timeout_b, m_tmo[1]);
      if (valid_a) log_a.push_back({d_a, t_a});
      if (valid_b) log_b.push_back({d_b, t_b});
      if (valid_a) since_valid = 0;
      else since_valid++;
      if (timeout_a && !tmo_prev) begin
        to_lat = since_valid;
        to_d = d_a;
        to_t = t_a;
      end
      tmo_prev = timeout_a;
    end
  end

  task automatic hold(input bit v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l, input int reps);
    repeat (reps) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  task automatic reset_pulse(input int n);
    reset = 1'b1;
    @(negedge clk);
    log_a.delete();
    log_b.delete();
    repeat (n - 1) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_log(input string name, input logic [31:0] got [$]);
    check({name, "_count"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++) check(name, got[i], want[i]);
  endtask

  task automatic want_n(input int d, input int t, input int n);
    repeat (n) want.push_back(pk(d, t));
  endtask

  initial begin
    // Reset values
    reset_pulse(2);
    check("rst_d", d_a, 0);
    check("rst_t", t_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_timeout", timeout_a, 0);

    // Steady 3/8: four periods give three reports of 3/11
    pulse(3, 8, 4);
    hold(1'b0, 6);
    want.delete(); want_n(3, 11, 3);
    check_log("steady_a", log_a);
    check_log("steady_b", log_b);

    // Extremes: 1/1 twice, then 100/1; the short watchdog trips on the long pulse
    reset_pulse(2);
    pulse(1, 1, 2);
    hold(1'b1, 100);
    hold(1'b0, 1);
    hold(1'b1, 1);
    hold(1'b0, 6);
    want.delete(); want_n(1, 2, 2); want_n(100, 101, 1);
    check_log("extreme_b", log_b);
    want.delete(); want_n(1, 2, 2);
    check_log("extreme_a", log_a);
    check("extreme_tmo_cleared", timeout_a, 0);

    // Timeout: one good period, stuck high, then resume
    reset_pulse(2);
    to_lat = -1;
    pulse(3, 8, 1);
    hold(1'b1, 63);
    check("tmo_set", timeout_a, 1);
    check("tmo_held_d", d_a, 3);
    check("tmo_held_t", t_a, 11);
    hold(1'b0, 8);
    pulse(3, 8, 2);
    hold(1'b0, 6);
    check("tmo_latency", to_lat, 49);
    check("tmo_d", to_d, 3);
    check("tmo_t", to_t, 11);
    check("tmo_cleared", timeout_a, 0);
    want.delete(); want_n(3, 11, 2);
    check_log("tmo_a", log_a);
    want.delete(); want_n(3, 11, 1); want_n(63, 71, 1); want_n(3, 11, 1);
    check_log("tmo_b", log_b);

    // Enable gating: drop during HIGH, re-enable while the input is high
    reset_pulse(2);
    pulse(3, 8, 2);
    hold(1'b1, 3);
    enable = 1'b0;
    hold(1'b0, 8);
    pulse(3, 8, 2);
    check("gate_held_d", d_a, 3);
    check("gate_held_t", t_a, 11);
    hold(1'b1, 4);
    enable = 1'b1;
    hold(1'b1, 2);
    hold(1'b0, 5);
    pulse(3, 8, 2);
    hold(1'b0, 6);
    want.delete(); want_n(3, 11, 3);
    check_log("gate_a", log_a);

    // Reset during LOW discards the partial period
    reset_pulse(2);
    pulse(4, 7, 2);
    hold(1'b1, 4);
    hold(1'b0, 3);
    want.delete(); want_n(4, 11, 2);
    check_log("prerst_a", log_a);
    reset_pulse(1);
    check("midrst_d", d_a, 0);
    check("midrst_t", t_a, 0);
    hold(1'b0, 3);
    pulse(3, 8, 3);
    hold(1'b0, 6);
    want.delete(); want_n(3, 11, 2);
    check_log("postrst_a", log_a);

    // Duty change at a period boundary
    reset_pulse(2);
    pulse(5, 15, 2);
    pulse(12, 8, 2);
    hold(1'b1, 5);
    hold(1'b0, 8);
    want.delete(); want_n(5, 20, 2); want_n(12, 20, 2);
    check_log("duty_a", log_a);
    check_log("duty_b", log_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
